// File: rtl/mult_datapath_if.sv
// mult_datapath_if: controller-to-datapath bundle for the shift/add multiplier.
interface mult_datapath_if #(parameter int N = 8);
  logic           clr;
  logic           ld;
  logic [1:0]     sel_a;
  logic [1:0]     sel_b;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           eq;
  logic [2*N-1:0] prod;
  logic [3:0]     steps;
  logic           valid;
  modport master (output clr, ld, sel_a, sel_b, a_in, b_in, input eq, prod, steps, valid);
  modport slave (input clr, ld, sel_a, sel_b, a_in, b_in, output eq, prod, steps, valid);
endinterface

// File: rtl/mult_datapath.sv
// mult_datapath: shift/add unsigned multiplier datapath with step counter and done flag.
module mult_datapath #(parameter int N = 8) (
  input logic            clk,
  input logic            rst,
  mult_datapath_if.slave bus
);
  logic [2*N-1:0] ra_q, ra_d, acc_q, acc_d;
  logic [N-1:0]   rb_q, rb_d;
  logic [3:0]     steps_q, steps_d;
  logic           valid_q, valid_d;
  logic           rb_load;
  always_comb begin
    rb_load = bus.sel_b == 2'b01;
    ra_d = bus.sel_a == 2'b01 ? {{N{1'b0}}, bus.a_in} :
           bus.sel_a == 2'b10 ? ra_q << 1 :
           bus.sel_a == 2'b11 ? ra_q >> 1 : ra_q;
    rb_d = rb_load ? bus.b_in :
           bus.sel_b == 2'b10 ? rb_q << 1 :
           bus.sel_b == 2'b11 ? rb_q >> 1 : rb_q;
    acc_d = bus.clr ? '0 : (bus.ld && rb_q[0]) ? acc_q + ra_q : acc_q;
    steps_d = (bus.clr || rb_load) ? 4'd0 :
              (bus.sel_b == 2'b11 && |rb_q && steps_q != 4'hf) ? steps_q + 4'd1 : steps_q;
    // a fresh multiplier operand invalidates any finished product
    valid_d = (bus.clr || rb_load) ? 1'b0 : (bus.ld && rb_q == '0) ? 1'b1 : valid_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ra_q    <= '0;
      rb_q    <= '0;
      acc_q   <= '0;
      steps_q <= '0;
      valid_q <= 1'b0;
    end else begin
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      acc_q   <= acc_d;
      steps_q <= steps_d;
      valid_q <= valid_d;
    end
  end
  assign bus.eq    = rb_q == '0;
  assign bus.prod  = acc_q;
  assign bus.steps = steps_q;
  assign bus.valid = valid_q;
endmodule

// File: tb/tb_mult_datapath.sv
// tb_mult_datapath: directed multiplier runs against an arithmetic operand/step model.
module tb_mult_datapath;
  localparam int N = 8;
  localparam int PMASK = (1 << (2 * N)) - 1;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  mult_datapath_if #(N) bus ();
  mult_datapath #(.N(N)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0, n_fail = 0;
  int m_a, m_b, m_k, m_base;
  bit m_valid, m_known = 1'b0;
  function automatic int bitlen(int v);
    int r = 0;
    while (v != 0) begin r++; v = v >> 1; end
    return r;
  endfunction
  function automatic int e_rb();
    return m_b >> m_k;
  endfunction
  // product so far = carried-in sum + multiplicand times the multiplier bits already consumed
  function automatic int e_prod();
    return (m_base + m_a * (m_b % (1 << m_k))) & PMASK;
  endfunction
  function automatic int e_steps();
    int s = bitlen(m_b) < m_k ? bitlen(m_b) : m_k;
    return s > 15 ? 15 : s;
  endfunction
  task automatic check(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (m_known) begin
    check("model_eq", int'(bus.eq), int'(e_rb() == 0));
    check("model_prod", int'(bus.prod), e_prod());
    check("model_steps", int'(bus.steps), e_steps());
    check("model_valid", int'(bus.valid), int'(m_valid));
  end
  task automatic cyc(bit r, bit c, bit l, logic [1:0] sa, logic [1:0] sb, int a, int b);
    rst = r; bus.clr = c; bus.ld = l; bus.sel_a = sa; bus.sel_b = sb;
    bus.a_in = N'(a); bus.b_in = N'(b);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    cyc(1, 0, 0, 2'b00, 2'b00, 0, 0);
    m_a = 0; m_b = 0; m_k = 0; m_base = 0; m_valid = 0; m_known = 1;
  endtask
  task automatic do_load(int a, int b);
    cyc(0, 1, 0, 2'b01, 2'b01, a, b);
    m_a = a; m_b = b; m_k = 0; m_base = 0; m_valid = 0;
  endtask
  task automatic do_load_acc(int a, int b);
    int add = (e_rb() & 1) != 0 ? ((m_a << m_k) & PMASK) : 0;
    int p = e_prod();
    cyc(0, 0, 1, 2'b01, 2'b01, a, b);
    m_base = (p + add) & PMASK; m_a = a; m_b = b; m_k = 0; m_valid = 0;
  endtask
  task automatic do_step();
    bit z = e_rb() == 0;
    cyc(0, 0, 1, 2'b10, 2'b11, 0, 0);
    if (z) m_valid = 1;
    m_k++;
  endtask
  task automatic do_hold();
    cyc(0, 0, 0, 2'b00, 2'b00, 0, 0);
  endtask
  task automatic finish_run(output int cycles);
    bit seen = 0;
    cycles = 0;
    while (!seen && cycles < N + 3) begin
      seen = bus.eq;
      do_step();
      cycles++;
    end
    check("eq_seen", int'(seen), 1);
  endtask
  task automatic run(int a, int b, int ep, int es, int ec);
    int c;
    do_load(a, b);
    finish_run(c);
    @(negedge clk);
    check("run_prod", int'(bus.prod), ep);
    check("run_steps", int'(bus.steps), es);
    check("run_valid", int'(bus.valid), 1);
    check("run_cycles", c, ec);
  endtask
  initial begin
    int c;
    do_reset();
    @(negedge clk);
    check("rst_prod", int'(bus.prod), 0);
    check("rst_eq", int'(bus.eq), 1);
    check("rst_valid", int'(bus.valid), 0);
    run(13, 11, 143, 4, 5);
    run(255, 255, 65025, 8, 9);
    run(200, 0, 0, 0, 1);
    run(7, 1, 7, 1, 2);
    run(1, 128, 128, 8, 9);
    run(0, 255, 0, 8, 9);
    do_load(13, 11);
    repeat (3) do_step();
    do_reset();
    @(negedge clk);
    check("abort_prod", int'(bus.prod), 0);
    check("abort_eq", int'(bus.eq), 1);
    check("abort_valid", int'(bus.valid), 0);
    check("abort_steps", int'(bus.steps), 0);
    run(13, 11, 143, 4, 5);
    repeat (6) do_hold();
    @(negedge clk);
    check("hold_prod", int'(bus.prod), 143);
    check("hold_valid", int'(bus.valid), 1);
    do_load(7, 1);
    m_known = 0;
    cyc(0, 1, 1, 2'b10, 2'b11, 0, 0);
    @(negedge clk);
    check("clr_wins_prod", int'(bus.prod), 0);
    check("clr_wins_steps", int'(bus.steps), 0);
    do_reset();
    do_load(7, 1);
    do_load_acc(3, 5);
    @(negedge clk);
    check("ldacc_prod", int'(bus.prod), 7);
    check("ldacc_steps", int'(bus.steps), 0);
    check("ldacc_valid", int'(bus.valid), 0);
    finish_run(c);
    @(negedge clk);
    check("ldacc_final", int'(bus.prod), 22);
    check("ldacc_fsteps", int'(bus.steps), 3);
    check("ldacc_cycles", c, 4);
    repeat (2) do_hold();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_datapath.md
MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 Parameter N, default 8, operand width in bits; product width is 2N.
REQ-002 CLK  input  1  system clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 CLR  input  1  clear accumulator and step counter (from multiplier controller).
REQ-005 SEL_A  input  2  multiplicand register mode: 00 hold, 01 parallel load, 10 shift left, 11 shift right.
REQ-006 SEL_B  input  2  multiplier register mode, same encoding as SEL_A.
REQ-007 LD  input  1  accumulator load enable (conditional add).
REQ-008 A_IN  input  N  multiplicand operand.
REQ-009 B_IN  input  N  multiplier operand.
REQ-010 EQ  output  1  high when multiplier register equals zero.
REQ-011 PROD  output  2N  accumulator contents, i.e. the product.
REQ-012 STEPS  output  4  number of shift steps applied to the multiplier since the last load.
REQ-013 VALID  output  1  product complete flag.

Function
REQ-014 Registers SHALL be: RA (2N bits, multiplicand), RB (N bits, multiplier), ACC (2N bits), STEPS (4 bits), VALID (1 bit).
REQ-015 SEL_A=01 SHALL load RA <= zero-extended A_IN; 10 SHALL shift RA left by 1, filling with 0; 11 SHALL shift RA right by 1, filling with 0; 00 SHALL hold RA.
REQ-016 SEL_B SHALL control RB with the same encoding; load SHALL take B_IN; shifts SHALL fill with 0.
REQ-017 EQ SHALL be combinational: EQ = (RB == 0).
REQ-018 When LD=1 and CLR=0, ACC SHALL become ACC + RA if RB[0]=1, else hold, using pre-edge RA and RB values; the sum SHALL be truncated to 2N bits.
REQ-019 CLR=1 SHALL set ACC to 0 and STEPS to 0, with priority over LD in the same cycle.
REQ-020 Register loads and shifts SHALL occur in the same edge as an accumulate; RA/RB updates are independent of CLR and LD.
REQ-021 A parallel load of RB (SEL_B=01) SHALL reset STEPS to 0 and clear VALID.
REQ-022 A right shift of RB (SEL_B=11) while RB != 0 SHALL increment STEPS, saturating at 15.
REQ-023 VALID SHALL be set on the edge where LD=1, RB==0 and CLR=0, and SHALL hold until RST, CLR or an RB parallel load.
REQ-024 With controller sequencing (load with CLR, then SEL_A=10, SEL_B=11, LD=1 until EQ), PROD SHALL equal A_IN*B_IN (unsigned) one cycle after EQ is first observed high, and VALID SHALL be 1 from that point.
REQ-025 Maximum multiply latency SHALL be N+1 cycles after load; STEPS at completion SHALL equal the bit position of B_IN's MSB plus 1.
REQ-026 B_IN=0: EQ SHALL be 1 the cycle after load; PROD SHALL stay 0.
REQ-027 SEL_x=01 with simultaneous LD=1 SHALL accumulate using old RA/RB and then load new operands.
REQ-028 Hold mode (SEL_A=SEL_B=00, LD=0, CLR=0) SHALL keep all registers and outputs stable indefinitely.

Reset
REQ-029 On RST=1 at a rising edge, RA, RB, ACC, STEPS and VALID SHALL all become 0, with priority over every other input.
REQ-030 After reset, EQ SHALL be 1 and PROD SHALL be 0.
REQ-031 RST asserted mid-multiply SHALL abort it; no partial product SHALL remain visible.

Verification
REQ-032 Scenario: load A=13, B=11 with CLR, then shift/accumulate -> EQ high after 4 steps; PROD=143; STEPS=4; VALID=1.
REQ-033 Scenario: A=255, B=255 -> PROD=65025 after 8 steps; STEPS=8; no truncation.
REQ-034 Scenario: A=200, B=0 -> EQ=1 the cycle after load; PROD=0; VALID=1 after the first LD cycle.
REQ-035 Scenario: A=7, B=1 -> one accumulate; PROD=7; STEPS=1.
REQ-036 Scenario: RST at step 3 of 13*11 -> next cycle all registers are 0, EQ=1, VALID=0; rerun gives 143.
REQ-037 Scenario: CLR=1 and LD=1 together with RB[0]=1 -> ACC=0 (CLR wins).
